// File: rtl/mode_step_encoder_if.sv
// Button inputs and mode outputs of the two-button mode stepper.
// The encoder takes the slave side; whoever drives the buttons takes the master side.
interface mode_step_encoder_if;
    logic       btn_next;
    logic       btn_prev;
    logic [1:0] value;
    logic       enable;
    logic       changed;

    modport master (
        output btn_next,
        output btn_prev,
        input  value,
        input  enable,
        input  changed
    );

    modport slave (
        input  btn_next,
        input  btn_prev,
        output value,
        output enable,
        output changed
    );
endinterface

// File: rtl/mode_step_encoder.sv
// Debounced two-button up/down stepper for a 2-bit mode code, one step per press, no auto-repeat.
// Latency: DEBOUNCE_CYCLES+3 cycles from raw press to value; no backpressure, the buttons are free-running.
module mode_step_encoder #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                CLK,
    input  logic                RST,
    mode_step_encoder_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_HELD,
        S_RELEASE
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [1:0]  sync_next_q;
    logic [1:0]  sync_prev_q;
    logic        snext;
    logic        sprev;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        dir_q, dir_d;
    logic [1:0]  value_q, value_d;
    logic        changed_q, changed_d;
    logic        enable_q;

    logic        sel_btn;
    logic        oth_btn;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_next_q <= 2'b00;
            sync_prev_q <= 2'b00;
        end else begin
            sync_next_q <= {sync_next_q[0], bus.btn_next};
            sync_prev_q <= {sync_prev_q[0], bus.btn_prev};
        end
    end

    assign snext   = sync_next_q[1];
    assign sprev   = sync_prev_q[1];
    assign sel_btn = dir_q ? snext : sprev;
    assign oth_btn = dir_q ? sprev : snext;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        value_d   = value_q;
        changed_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // Both pressed together is ambiguous; wait until one lets go.
                if (snext ^ sprev) begin
                    state_d = S_DEBOUNCE;
                    dir_d   = snext;
                    cnt_d   = '0;
                end
            end
            S_DEBOUNCE: begin
                if (sel_btn && !oth_btn) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d   = S_HELD;
                        cnt_d     = '0;
                        changed_d = 1'b1;
                        value_d   = dir_q ? value_q + 2'd1 : value_q - 2'd1;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end else begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            S_HELD: begin
                if (!snext && !sprev) begin
                    state_d = S_RELEASE;
                    cnt_d   = '0;
                end
            end
            S_RELEASE: begin
                if (snext || sprev) begin
                    state_d = S_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            value_q   <= 2'b00;
            changed_q <= 1'b0;
            enable_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            value_q   <= value_d;
            changed_q <= changed_d;
            enable_q  <= (state_d == S_IDLE);
        end
    end

    assign bus.value   = value_q;
    assign bus.enable  = enable_q;
    assign bus.changed = changed_q;

endmodule

// File: tb/tb_mode_step_encoder.sv
// Directed bench for mode_step_encoder with DEBOUNCE_CYCLES=4; expected values are hand-derived.
module tb_mode_step_encoder;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   n_chg;

    mode_step_encoder_if bus ();

    mode_step_encoder #(.DEBOUNCE_CYCLES(4)) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.changed === 1'b1) n_chg++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Press one button for hold cycles, release, and let the release debounce finish.
    task automatic press(input logic nxt, input int hold);
        if (nxt) bus.btn_next = 1'b1;
        else     bus.btn_prev = 1'b1;
        repeat (hold) tick();
        bus.btn_next = 1'b0;
        bus.btn_prev = 1'b0;
        repeat (10) tick();
    endtask

    initial begin
        int c0;
        logic en_and;
        logic en_or;
        logic [1:0] exp_seq [5];
        exp_seq[0] = 2'd1; exp_seq[1] = 2'd2; exp_seq[2] = 2'd3; exp_seq[3] = 2'd0; exp_seq[4] = 2'd3;

        n_checks = 0;
        n_fail = 0;
        n_chg = 0;
        rst_n = 1'b0;
        bus.btn_next = 1'b0;
        bus.btn_prev = 1'b0;

        // Reset values before any clock edge.
        #3;
        check_eq("rst_value", 32'(bus.value), 0);
        check_eq("rst_enable", 32'(bus.enable), 0);
        check_eq("rst_changed", 32'(bus.changed), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("enable_first_edge", 32'(bus.enable), 1);

        // Long press: value visible on the 7th edge after the raw edge.
        c0 = n_chg;
        bus.btn_next = 1'b1;
        repeat (6) tick();
        check_eq("lat_before_value", 32'(bus.value), 0);
        check_eq("lat_before_enable", 32'(bus.enable), 0);
        tick();
        check_eq("lat_value", 32'(bus.value), 1);
        check_eq("lat_changed", 32'(bus.changed), 1);
        tick();
        check_eq("changed_one_cycle", 32'(bus.changed), 0);
        repeat (12) tick();
        bus.btn_next = 1'b0;
        repeat (6) tick();
        check_eq("release_enable_low", 32'(bus.enable), 0);
        tick();
        check_eq("release_enable_high", 32'(bus.enable), 1);
        check_eq("long_press_pulses", 32'(n_chg - c0), 1);

        // Four next presses then one prev press from 0.
        apply_reset();
        c0 = n_chg;
        for (int i = 0; i < 5; i++) begin
            press(i < 4, 8);
            check_eq($sformatf("seq_value_%0d", i), 32'(bus.value), 32'(exp_seq[i]));
        end
        check_eq("seq_pulses", 32'(n_chg - c0), 5);

        // Two-cycle glitch: enable dips, value holds at 3.
        c0 = n_chg;
        en_and = 1'b1;
        bus.btn_next = 1'b1;
        tick();
        en_and &= bus.enable;
        tick();
        en_and &= bus.enable;
        bus.btn_next = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            en_and &= bus.enable;
        end
        check_eq("glitch_enable_dipped", 32'(en_and), 0);
        check_eq("glitch_enable_back", 32'(bus.enable), 1);
        check_eq("glitch_value", 32'(bus.value), 3);
        check_eq("glitch_pulses", 32'(n_chg - c0), 0);

        // Both buttons together are ignored.
        c0 = n_chg;
        en_and = 1'b1;
        bus.btn_next = 1'b1;
        bus.btn_prev = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            en_and &= bus.enable;
        end
        bus.btn_next = 1'b0;
        bus.btn_prev = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            en_and &= bus.enable;
        end
        check_eq("both_enable", 32'(en_and), 1);
        check_eq("both_value", 32'(bus.value), 3);
        check_eq("both_pulses", 32'(n_chg - c0), 0);

        // Hold 100 cycles, then a one-cycle bounce during the release debounce.
        c0 = n_chg;
        bus.btn_next = 1'b1;
        repeat (100) tick();
        check_eq("hold_value", 32'(bus.value), 0);
        check_eq("hold_pulses", 32'(n_chg - c0), 1);
        bus.btn_next = 1'b0;
        repeat (3) tick();
        bus.btn_next = 1'b1;
        tick();
        bus.btn_next = 1'b0;
        repeat (3) tick();
        check_eq("bounce_enable_low", 32'(bus.enable), 0);
        en_or = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            en_or |= bus.enable;
        end
        check_eq("bounce_enable_back", 32'(en_or), 1);
        check_eq("bounce_value", 32'(bus.value), 0);
        check_eq("bounce_pulses", 32'(n_chg - c0), 1);

        // Step to 1, then reset at cnt=2 of the next debounce.
        press(1'b1, 8);
        check_eq("pre_abort_value", 32'(bus.value), 1);
        c0 = n_chg;
        bus.btn_next = 1'b1;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check_eq("abort_value", 32'(bus.value), 0);
        check_eq("abort_enable", 32'(bus.enable), 0);
        check_eq("abort_changed", 32'(bus.changed), 0);
        bus.btn_next = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check_eq("abort_after_value", 32'(bus.value), 0);
        check_eq("abort_after_enable", 32'(bus.enable), 1);
        check_eq("abort_pulses", 32'(n_chg - c0), 0);

        // Button already held when reset lifts counts as a new press.
        rst_n = 1'b0;
        bus.btn_next = 1'b1;
        #1;
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("held_rst_enable", 32'(bus.enable), 1);
        repeat (5) tick();
        check_eq("held_rst_before", 32'(bus.value), 0);
        tick();
        check_eq("held_rst_value", 32'(bus.value), 1);
        bus.btn_next = 1'b0;
        repeat (10) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
